mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge.sv | 146 ++++++++++++++
 tb/tb_mem_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: single-port word memory behind a fixed-latency request/response FSM.
//
// A request (memory_rden or memory_wren level) is accepted in IDLE. The
// address, write data and operation are captured, then the block waits so
// that the access edge falls LATENCY edges after acceptance. memory_response
// pulses for the one cycle that follows the access edge, and the FSM then
// returns to IDLE. Requests seen in WAIT or RESP are ignored, so requests are
// accepted at most once every LATENCY+2 edges.
//
// Parameters
//   DATA_W  - word width in bits
//   DEPTH   - number of storage words (power of two)
//   LATENCY - edges from acceptance to the access edge (1..15)
//
// Ports
//   clk              - clock, all state changes on the rising edge
//   reset            - synchronous active-high reset (storage is not cleared)
//   memory_addr      - word address, low log2(DEPTH) bits index storage
//   memory_rden      - read request level
//   memory_wren      - write request level (wins when both are high)
//   memory_write_val - write data
//   memory_read_val  - registered read data / echo of the last written word
//   memory_response  - one-cycle completion pulse
//   busy             - high whenever the FSM is not in IDLE
//   mem_err          - range error, valid with memory_response
//
// Build option
//   MEM_BRIDGE_RANGE_CHECK_EN - when defined, an address with any bit at or
//   above log2(DEPTH) set completes normally but does not write storage,
//   returns 0 and raises mem_err with the response. When undefined, upper
//   address bits are ignored (accesses wrap modulo DEPTH) and mem_err is 0.

module mem_bridge #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       memory_addr,
    input  logic              memory_rden,
    input  logic              memory_wren,
    input  logic [DATA_W-1:0] memory_write_val,
    output logic [DATA_W-1:0] memory_read_val,
    output logic              memory_response,
    output logic              busy,
    output logic              mem_err
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              oob_q;      // address was out of range at acceptance
    logic              addr_oob;
    logic              access;

    logic [DATA_W-1:0] storage [DEPTH];

`ifdef MEM_BRIDGE_RANGE_CHECK_EN
    assign addr_oob = |memory_addr[31:IDX_W];
`else
    // Upper address bits are deliberately ignored: accesses alias modulo DEPTH.
    logic unused_addr_hi;
    assign unused_addr_hi = ^memory_addr[31:IDX_W];
    assign addr_oob       = 1'b0;
`endif

    // Access edge: the counter has run out while waiting.
    assign access = (state_q == StWait) && (cnt_q == 4'd0);

    // Storage has no reset; a write is only committed on the access edge, so a
    // reset that lands while waiting drops the write.
    always_ff @(posedge clk) begin
        if (!reset && access && write_q && !oob_q) begin
            storage[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            cnt_q           <= 4'd0;
            idx_q           <= '0;
            wdata_q         <= '0;
            write_q         <= 1'b0;
            oob_q           <= 1'b0;
            memory_read_val <= '0;
            memory_response <= 1'b0;
            busy            <= 1'b0;
            mem_err         <= 1'b0;
        end else begin
            // Both flags are single-cycle pulses.
            memory_response <= 1'b0;
            mem_err         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (memory_rden || memory_wren) begin
                        idx_q   <= memory_addr[IDX_W-1:0];
                        wdata_q <= memory_write_val;
                        write_q <= memory_wren;
                        oob_q   <= addr_oob;
                        cnt_q   <= CNT_INIT;
                        state_q <= StWait;
                        busy    <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q         <= StResp;
                        memory_response <= 1'b1;
                        mem_err         <= oob_q;
                        if (oob_q) begin
                            memory_read_val <= '0;
                        end else if (write_q) begin
                            memory_read_val <= wdata_q;
                        end else begin
                            memory_read_val <= storage[idx_q];
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge. A transaction-level model (an array of
// words plus the completion rules) predicts every response; the main instance
// runs at LATENCY=2 and two extra instances cover LATENCY=1 and LATENCY=15.

module tb_mem_bridge;

    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] memory_addr;
    logic        memory_rden;
    logic        memory_wren;
    logic [31:0] memory_write_val;
    logic [31:0] memory_read_val;
    logic        memory_response;
    logic        busy;
    logic        mem_err;

    logic [31:0] sw_addr;
    logic        sw_rden;
    logic        sw_wren;
    logic [31:0] sw_wval;
    logic [31:0] l1_rval, l15_rval;
    logic        l1_resp, l15_resp, l1_busy, l15_busy, l1_err, l15_err;

    mem_bridge #(.DATA_W(32), .DEPTH(256), .LATENCY(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .memory_addr      (memory_addr),
        .memory_rden      (memory_rden),
        .memory_wren      (memory_wren),
        .memory_write_val (memory_write_val),
        .memory_read_val  (memory_read_val),
        .memory_response  (memory_response),
        .busy             (busy),
        .mem_err          (mem_err)
    );

    mem_bridge #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) dut_l1 (
        .clk              (clk),
        .reset            (reset),
        .memory_addr      (sw_addr),
        .memory_rden      (sw_rden),
        .memory_wren      (sw_wren),
        .memory_write_val (sw_wval),
        .memory_read_val  (l1_rval),
        .memory_response  (l1_resp),
        .busy             (l1_busy),
        .mem_err          (l1_err)
    );

    mem_bridge #(.DATA_W(32), .DEPTH(256), .LATENCY(15)) dut_l15 (
        .clk              (clk),
        .reset            (reset),
        .memory_addr      (sw_addr),
        .memory_rden      (sw_rden),
        .memory_wren      (sw_wren),
        .memory_write_val (sw_wval),
        .memory_read_val  (l15_rval),
        .memory_response  (l15_resp),
        .busy             (l15_busy),
        .mem_err          (l15_err)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mmem [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model of one completed access.
    function automatic void model_access(input logic wr, input logic [31:0] a,
                                         input logic [31:0] d,
                                         output logic [31:0] rv, output logic err);
        logic [7:0] idx;
        idx = a[7:0];
`ifdef MEM_BRIDGE_RANGE_CHECK_EN
        if ((a >> 8) != 32'd0) begin
            rv  = 32'd0;
            err = 1'b1;
            return;
        end
`endif
        err = 1'b0;
        if (wr) begin
            mmem[idx] = d;
            rv        = d;
        end else begin
            rv = mmem[idx];
        end
    endfunction

    // One request on the main instance, starting from IDLE just after an edge.
    // Inputs are scrambled after acceptance; the DUT must ignore them.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
        logic [31:0] exp_rv;
        logic        exp_err;
        model_access(wr, a, d, exp_rv, exp_err);
        memory_rden      = rd;
        memory_wren      = wr;
        memory_addr      = a;
        memory_write_val = d;
        @(posedge clk);
        #1;
        check("accept_busy", {63'd0, busy}, 64'd1);
        check("accept_resp", {63'd0, memory_response}, 64'd0);
        memory_rden      = 1'($urandom);
        memory_wren      = 1'($urandom);
        memory_addr      = $urandom;
        memory_write_val = $urandom;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            if (k < LAT) begin
                check("wait_resp", {63'd0, memory_response}, 64'd0);
                check("wait_busy", {63'd0, busy}, 64'd1);
            end else if (k == LAT) begin
                check("resp_pulse", {63'd0, memory_response}, 64'd1);
                check("resp_busy", {63'd0, busy}, 64'd1);
                check("resp_rval", {32'd0, memory_read_val}, {32'd0, exp_rv});
                check("resp_err", {63'd0, mem_err}, {63'd0, exp_err});
            end else begin
                check("idle_resp", {63'd0, memory_response}, 64'd0);
                check("idle_busy", {63'd0, busy}, 64'd0);
                check("idle_err", {63'd0, mem_err}, 64'd0);
                check("hold_rval", {32'd0, memory_read_val}, {32'd0, exp_rv});
            end
        end
        memory_rden = 1'b0;
        memory_wren = 1'b0;
    endtask

    // One request on both sweep instances; checks pulse position and busy span.
    task automatic sweep(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rv);
        int n1;
        int n15;
        n1      = 0;
        n15     = 0;
        sw_rden = ~wr;
        sw_wren = wr;
        sw_addr = a;
        sw_wval = d;
        @(posedge clk);
        #1;
        check("l1_accept_busy", {63'd0, l1_busy}, 64'd1);
        check("l15_accept_busy", {63'd0, l15_busy}, 64'd1);
        sw_rden = 1'b0;
        sw_wren = 1'b0;
        sw_addr = $urandom;
        sw_wval = $urandom;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            n1  += int'(l1_resp);
            n15 += int'(l15_resp);
            check("l1_resp", {63'd0, l1_resp}, {63'd0, k == 1});
            check("l1_busy", {63'd0, l1_busy}, {63'd0, k <= 1});
            check("l15_resp", {63'd0, l15_resp}, {63'd0, k == 15});
            check("l15_busy", {63'd0, l15_busy}, {63'd0, k <= 15});
            if (k == 1) check("l1_rval", {32'd0, l1_rval}, {32'd0, exp_rv});
            if (k == 15) check("l15_rval", {32'd0, l15_rval}, {32'd0, exp_rv});
            if (k == 15) check("sweep_err", {62'd0, l1_err, l15_err}, 64'd0);
        end
        check("l1_pulses", 64'(n1), 64'd1);
        check("l15_pulses", 64'(n15), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addrs [16];
        logic [31:0] prior7;
        logic [31:0] d;
        logic        rd;
        logic        wr;

        reset            = 1'b1;
        memory_addr      = '0;
        memory_rden      = 1'b0;
        memory_wren      = 1'b0;
        memory_write_val = '0;
        sw_addr          = '0;
        sw_rden          = 1'b0;
        sw_wren          = 1'b0;
        sw_wval          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp", {63'd0, memory_response}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, mem_err}, 64'd0);
        check("rst_rval", {32'd0, memory_read_val}, 64'd0);
        reset = 1'b0;

        // Known contents everywhere so every later read has a defined answer.
        for (int i = 0; i < 256; i++) txn(1'b0, 1'b1, 32'(i), $urandom);

        // Directed: write/read, both-high as write, out-of-range address.
        txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'd5, 32'd0);
        txn(1'b1, 1'b1, 32'd3, 32'h12345678);
        txn(1'b1, 1'b0, 32'd3, 32'd0);
        txn(1'b0, 1'b1, 32'h100, 32'hCAFEF00D);
        txn(1'b1, 1'b0, 32'd0, 32'd0);
        txn(1'b1, 1'b0, 32'h100, 32'd0);

        // Latency sweep: write then read back on the LATENCY=1/15 instances.
        d = $urandom;
        sweep(1'b1, 32'd9, d, d);
        sweep(1'b0, 32'd9, 32'd0, d);

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            if ($urandom_range(0, 7) == 0) txn(rd, wr, $urandom, $urandom);
            else txn(rd, wr, 32'($urandom_range(0, 255)), $urandom);
        end

        // rden held high: acceptance every LAT+2 edges, address churn ignored.
        memory_rden = 1'b1;
        memory_wren = 1'b0;
        for (int k = 0; k < 16; k++) begin
            addrs[k]    = 32'($urandom_range(0, 255));
            memory_addr = addrs[k];
            @(posedge clk);
            #1;
            if (k % 4 == 2) begin
                check("held_resp", {63'd0, memory_response}, 64'd1);
                check("held_rval", {32'd0, memory_read_val}, {32'd0, mmem[addrs[k-2][7:0]]});
            end else begin
                check("held_noresp", {63'd0, memory_response}, 64'd0);
            end
        end
        memory_rden = 1'b0;
        @(posedge clk);
        #1;

        // Reset one cycle into WAIT aborts a write of addr 7.
        prior7           = mmem[7];
        memory_wren      = 1'b1;
        memory_addr      = 32'd7;
        memory_write_val = 32'h0000AAAA;
        @(posedge clk);
        #1;
        memory_wren = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_rval", {32'd0, memory_read_val}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_err", {63'd0, mem_err}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            check("abort_noresp", {63'd0, memory_response}, 64'd0);
            @(posedge clk);
            #1;
        end
        check("abort_mem_kept", {32'd0, mmem[7]}, {32'd0, prior7});
        txn(1'b1, 1'b0, 32'd7, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
